// File: rtl/amb_paylasim_denetleyicisi.sv
`default_nettype none
// ============================================================================
// Module   : amb_paylasim_denetleyicisi
// Purpose  : Shares one combinational ALU between two requesters.
//            - Each port has a valid/ready handshake for the request and for
//              the result.
//            - Arbitration is round-robin.
//            - Operands and the ALU result are both registered.
// Revision : 1.0 - initial release
// ============================================================================
module amb_paylasim_denetleyicisi #(
    parameter int VERI_GENISLIGI  = 32,
    parameter int ISLEV_GENISLIGI = 12
) (
    input  logic                       clk_g,
    input  logic                       rst_g,

    input  logic                       istek0_gecerli_g,
    output logic                       istek0_hazir_c,
    input  logic [ISLEV_GENISLIGI-1:0] istek0_islev_kodu_g,
    input  logic [VERI_GENISLIGI-1:0]  istek0_islec1_g,
    input  logic [VERI_GENISLIGI-1:0]  istek0_islec2_g,

    input  logic                       istek1_gecerli_g,
    output logic                       istek1_hazir_c,
    input  logic [ISLEV_GENISLIGI-1:0] istek1_islev_kodu_g,
    input  logic [VERI_GENISLIGI-1:0]  istek1_islec1_g,
    input  logic [VERI_GENISLIGI-1:0]  istek1_islec2_g,

    output logic                       sonuc0_gecerli_c,
    input  logic                       sonuc0_hazir_g,
    output logic                       sonuc1_gecerli_c,
    input  logic                       sonuc1_hazir_g,
    output logic [VERI_GENISLIGI-1:0]  sonuc_c,

    output logic [ISLEV_GENISLIGI-1:0] amb_islev_kodu_c,
    output logic [VERI_GENISLIGI-1:0]  amb_islec1_c,
    output logic [VERI_GENISLIGI-1:0]  amb_islec2_c,
    input  logic [VERI_GENISLIGI-1:0]  amb_sonuc_g,

    output logic                       mesgul_c
);

    localparam logic [1:0] c_bosta   = 2'd0;
    localparam logic [1:0] c_hesapla = 2'd1;
    localparam logic [1:0] c_sonuc   = 2'd2;

    logic [1:0] r_durum;
    logic [1:0] w_sonraki_durum;
    logic       r_oncelik;
    logic       r_sahip;
    logic       w_istek_var;
    logic       w_verilen;
    logic       w_kabul;
    logic       w_tuketim;

    // Round-robin pick: a lone requester wins, a tie goes to the priority port.
    always_comb begin
        w_istek_var = istek0_gecerli_g | istek1_gecerli_g;
        if (istek0_gecerli_g && istek1_gecerli_g) begin
            w_verilen = r_oncelik;
        end else begin
            w_verilen = istek1_gecerli_g;
        end
    end

    // Next-state and handshake outputs.
    // Ready is held low while reset is asserted so that nothing is accepted.
    always_comb begin
        w_sonraki_durum  = r_durum;
        istek0_hazir_c   = 1'b0;
        istek1_hazir_c   = 1'b0;
        sonuc0_gecerli_c = 1'b0;
        sonuc1_gecerli_c = 1'b0;
        mesgul_c         = 1'b0;
        w_kabul          = 1'b0;
        w_tuketim        = 1'b0;
        case (r_durum)
            c_bosta: begin
                if (w_istek_var && !rst_g) begin
                    istek0_hazir_c  = ~w_verilen;
                    istek1_hazir_c  = w_verilen;
                    w_kabul         = 1'b1;
                    w_sonraki_durum = c_hesapla;
                end
            end
            c_hesapla: begin
                mesgul_c        = 1'b1;
                w_sonraki_durum = c_sonuc;
            end
            c_sonuc: begin
                mesgul_c         = 1'b1;
                sonuc0_gecerli_c = ~r_sahip;
                sonuc1_gecerli_c = r_sahip;
                w_tuketim        = r_sahip ? sonuc1_hazir_g : sonuc0_hazir_g;
                if (w_tuketim) begin
                    w_sonraki_durum = c_bosta;
                end
            end
            default: begin
                w_sonraki_durum = c_bosta;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_g or posedge rst_g) begin
        if (rst_g) begin
            r_durum <= c_bosta;
        end else begin
            r_durum <= w_sonraki_durum;
        end
    end

    // Datapath registers.
    // - On accept: capture the granted request and rotate priority.
    // - In the compute cycle: capture the ALU result.
    always_ff @(posedge clk_g or posedge rst_g) begin
        if (rst_g) begin
            r_oncelik        <= 1'b0;
            r_sahip          <= 1'b0;
            amb_islev_kodu_c <= '0;
            amb_islec1_c     <= '0;
            amb_islec2_c     <= '0;
            sonuc_c          <= '0;
        end else begin
            if (w_kabul) begin
                r_sahip   <= w_verilen;
                r_oncelik <= ~w_verilen;
                if (w_verilen) begin
                    amb_islev_kodu_c <= istek1_islev_kodu_g;
                    amb_islec1_c     <= istek1_islec1_g;
                    amb_islec2_c     <= istek1_islec2_g;
                end else begin
                    amb_islev_kodu_c <= istek0_islev_kodu_g;
                    amb_islec1_c     <= istek0_islec1_g;
                    amb_islec2_c     <= istek0_islec2_g;
                end
            end
            if (r_durum == c_hesapla) begin
                sonuc_c <= amb_sonuc_g;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_amb_paylasim_denetleyicisi.sv
`default_nettype none
// ============================================================================
// Module   : tb_amb_paylasim_denetleyicisi
// Purpose  : Scoreboard bench for the shared ALU controller.
//            - A small ALU model stands in for the real ALU.
//            - Accepted requests push their expected results into per-port
//              queues.
//            - A monitor pops and compares each result as it is consumed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_amb_paylasim_denetleyicisi;

    localparam logic [11:0] c_add = 12'h001;
    localparam logic [11:0] c_sub = 12'h002;
    localparam logic [11:0] c_and = 12'h003;
    localparam logic [11:0] c_or  = 12'h004;
    localparam logic [11:0] c_xor = 12'h005;
    localparam logic [11:0] c_sll = 12'h006;

    logic        clk_g = 1'b0;
    logic        rst_g = 1'b1;
    logic        istek0_gecerli_g = 1'b0, istek1_gecerli_g = 1'b0;
    logic        istek0_hazir_c, istek1_hazir_c;
    logic [11:0] istek0_islev_kodu_g = '0, istek1_islev_kodu_g = '0;
    logic [31:0] istek0_islec1_g = '0, istek0_islec2_g = '0;
    logic [31:0] istek1_islec1_g = '0, istek1_islec2_g = '0;
    logic        sonuc0_gecerli_c, sonuc1_gecerli_c;
    logic        sonuc0_hazir_g = 1'b0, sonuc1_hazir_g = 1'b0;
    logic [31:0] sonuc_c;
    logic [11:0] amb_islev_kodu_c;
    logic [31:0] amb_islec1_c, amb_islec2_c;
    logic [31:0] amb_sonuc_g;
    logic        mesgul_c;

    int          n_test = 0;
    int          n_hata = 0;
    int          cyc    = 0;
    logic [31:0] q_deger [2][$];
    int          q_cyc   [2][$];
    bit          ilk     [2];
    bit          bosta_bekle = 1'b0;
    int          kabul_sirasi[$];

    amb_paylasim_denetleyicisi dut (
        .clk_g               (clk_g),
        .rst_g               (rst_g),
        .istek0_gecerli_g    (istek0_gecerli_g),
        .istek0_hazir_c      (istek0_hazir_c),
        .istek0_islev_kodu_g (istek0_islev_kodu_g),
        .istek0_islec1_g     (istek0_islec1_g),
        .istek0_islec2_g     (istek0_islec2_g),
        .istek1_gecerli_g    (istek1_gecerli_g),
        .istek1_hazir_c      (istek1_hazir_c),
        .istek1_islev_kodu_g (istek1_islev_kodu_g),
        .istek1_islec1_g     (istek1_islec1_g),
        .istek1_islec2_g     (istek1_islec2_g),
        .sonuc0_gecerli_c    (sonuc0_gecerli_c),
        .sonuc0_hazir_g      (sonuc0_hazir_g),
        .sonuc1_gecerli_c    (sonuc1_gecerli_c),
        .sonuc1_hazir_g      (sonuc1_hazir_g),
        .sonuc_c             (sonuc_c),
        .amb_islev_kodu_c    (amb_islev_kodu_c),
        .amb_islec1_c        (amb_islec1_c),
        .amb_islec2_c        (amb_islec2_c),
        .amb_sonuc_g         (amb_sonuc_g),
        .mesgul_c            (mesgul_c)
    );

    always #5 clk_g = ~clk_g;

    always @(posedge clk_g) cyc <= cyc + 1;

    // Reference ALU behaviour.
    // It also serves as the combinational ALU attached to the controller.
    function automatic logic [31:0] ref_alu(input logic [11:0] k, input logic [31:0] a,
                                            input logic [31:0] b);
        case (k)
            c_add:   return a + b;
            c_sub:   return a - b;
            c_and:   return a & b;
            c_or:    return a | b;
            c_xor:   return a ^ b;
            c_sll:   return a << b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    assign amb_sonuc_g = ref_alu(amb_islev_kodu_c, amb_islec1_c, amb_islec2_c);

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        n_test++;
        if (gercek !== beklenen) begin
            n_hata++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", ad, gercek, beklenen, cyc);
        end
    endtask

    // Monitor: records accepts into the scoreboard and checks every presented result.
    always @(negedge clk_g) begin
        bit hz[2];
        bit gc[2];
        bit sg[2];
        bit sh[2];
        hz[0] = istek0_hazir_c;   hz[1] = istek1_hazir_c;
        gc[0] = istek0_gecerli_g; gc[1] = istek1_gecerli_g;
        sg[0] = sonuc0_gecerli_c; sg[1] = sonuc1_gecerli_c;
        sh[0] = sonuc0_hazir_g;   sh[1] = sonuc1_hazir_g;
        if (!rst_g) begin
            if (bosta_bekle) begin
                kontrol("idle_after_consume", 32'(mesgul_c), 0);
                bosta_bekle = 1'b0;
            end
            if (sg[0] || sg[1]) begin
                kontrol("single_result_valid", 32'(sg[0] && sg[1]), 0);
                kontrol("busy_with_result", 32'(mesgul_c), 1);
            end
            for (int p = 0; p < 2; p++) begin
                if (hz[p]) begin
                    kontrol("ready_only_when_idle", 32'(mesgul_c), 0);
                    kontrol("single_ready", 32'(hz[1-p]), 0);
                    kontrol("ready_needs_valid", 32'(gc[p]), 1);
                    if (gc[p]) begin
                        if (p == 0)
                            q_deger[0].push_back(ref_alu(istek0_islev_kodu_g, istek0_islec1_g, istek0_islec2_g));
                        else
                            q_deger[1].push_back(ref_alu(istek1_islev_kodu_g, istek1_islec1_g, istek1_islec2_g));
                        q_cyc[p].push_back(cyc);
                        kabul_sirasi.push_back(p);
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (sg[p]) begin
                    kontrol("result_expected", 32'(q_deger[p].size() != 0), 1);
                    if (q_deger[p].size() != 0) begin
                        kontrol("result_value", sonuc_c, q_deger[p][0]);
                        if (!ilk[p]) begin
                            kontrol("result_latency", 32'(cyc - q_cyc[p][0]), 2);
                            ilk[p] = 1'b1;
                        end
                        if (sh[p]) begin
                            void'(q_deger[p].pop_front());
                            void'(q_cyc[p].pop_front());
                            ilk[p]      = 1'b0;
                            bosta_bekle = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Present a request on port p and hold it until it is accepted.
    task automatic gonder(input int p, input logic [11:0] k, input logic [31:0] a, input logic [31:0] b);
        bit bitti;
        bitti = 1'b0;
        if (p == 0) begin
            istek0_islev_kodu_g = k; istek0_islec1_g = a; istek0_islec2_g = b; istek0_gecerli_g = 1'b1;
        end else begin
            istek1_islev_kodu_g = k; istek1_islec1_g = a; istek1_islec2_g = b; istek1_gecerli_g = 1'b1;
        end
        for (int i = 0; i < 300 && !bitti; i++) begin
            @(negedge clk_g);
            if ((p == 0 && istek0_hazir_c) || (p == 1 && istek1_hazir_c)) begin
                @(posedge clk_g);
                #1;
                bitti = 1'b1;
            end
        end
        if (p == 0) istek0_gecerli_g = 1'b0;
        else        istek1_gecerli_g = 1'b0;
        kontrol("request_accepted", 32'(bitti), 1);
    endtask

    // Wait (bounded) until port p presents a result; returns at that negedge.
    task automatic bekle_sonuc(input int p);
        bit g;
        g = 1'b0;
        for (int i = 0; i < 50 && !g; i++) begin
            @(negedge clk_g);
            g = (p == 0) ? sonuc0_gecerli_c : sonuc1_gecerli_c;
        end
        kontrol("result_arrives", 32'(g), 1);
    endtask

    task automatic sifir_kontrol();
        kontrol("rst_istek0_hazir", 32'(istek0_hazir_c), 0);
        kontrol("rst_istek1_hazir", 32'(istek1_hazir_c), 0);
        kontrol("rst_sonuc0_gecerli", 32'(sonuc0_gecerli_c), 0);
        kontrol("rst_sonuc1_gecerli", 32'(sonuc1_gecerli_c), 0);
        kontrol("rst_sonuc", sonuc_c, 0);
        kontrol("rst_amb_kod", 32'(amb_islev_kodu_c), 0);
        kontrol("rst_amb_islec1", amb_islec1_c, 0);
        kontrol("rst_amb_islec2", amb_islec2_c, 0);
        kontrol("rst_mesgul", 32'(mesgul_c), 0);
    endtask

    task automatic sifirla();
        rst_g = 1'b1;
        q_deger[0].delete(); q_deger[1].delete();
        q_cyc[0].delete();   q_cyc[1].delete();
        ilk[0] = 1'b0; ilk[1] = 1'b0;
        bosta_bekle = 1'b0;
        repeat (2) @(posedge clk_g);
        #1 rst_g = 1'b0;
    endtask

    task automatic sira_kontrol(input int n);
        int bek[$];
        for (int i = 0; i < n; i++) bek.push_back(i % 2);
        kontrol("grant_count", 32'(kabul_sirasi.size()), 32'(n));
        for (int i = 0; i < n && i < kabul_sirasi.size(); i++)
            kontrol("grant_order", 32'(kabul_sirasi[i]), 32'(bek[i]));
    endtask

    initial begin
        bit d0;
        bit d1;
        logic [11:0] kodlar[6];
        kodlar[0] = c_add; kodlar[1] = c_sub; kodlar[2] = c_and;
        kodlar[3] = c_or;  kodlar[4] = c_xor; kodlar[5] = c_sll;

        // Reset state
        #3 sifir_kontrol();
        repeat (2) @(posedge clk_g);
        #1 rst_g = 1'b0;

        // 1: single port ADD
        sonuc0_hazir_g = 1'b1; sonuc1_hazir_g = 1'b1;
        gonder(0, c_add, 32'd5, 32'd7);
        bekle_sonuc(0);
        kontrol("t1_sum", sonuc_c, 32'd12);
        kontrol("t1_other_valid", 32'(sonuc1_gecerli_c), 0);
        repeat (2) @(negedge clk_g);
        kontrol("t1_idle", 32'(mesgul_c), 0);

        // 2: both valid from reset, port 0 first
        sifirla();
        kabul_sirasi.delete();
        fork
            gonder(0, c_sub, 32'd10, 32'd3);
            gonder(1, c_xor, 32'hFF, 32'h0F);
        join
        repeat (6) @(negedge clk_g);
        sira_kontrol(2);

        // 3: port 1 result stalled for 5 cycles while port 0 waits
        @(posedge clk_g); #1;
        sonuc1_hazir_g = 1'b0;
        gonder(1, c_sll, 32'd1, 32'd4);
        istek0_islev_kodu_g = c_add; istek0_islec1_g = 32'd100; istek0_islec2_g = 32'd23;
        istek0_gecerli_g = 1'b1;
        bekle_sonuc(1);
        for (int i = 0; i < 5; i++) begin
            kontrol("t3_stall_valid", 32'(sonuc1_gecerli_c), 1);
            kontrol("t3_stall_value", sonuc_c, 32'd16);
            kontrol("t3_waiter_ready", 32'(istek0_hazir_c), 0);
            @(negedge clk_g);
        end
        @(posedge clk_g); #1 sonuc1_hazir_g = 1'b1;
        @(negedge clk_g);
        kontrol("t3_consume_cycle_valid", 32'(sonuc1_gecerli_c), 1);
        @(posedge clk_g); #1;
        kontrol("t3_after_consume", 32'(sonuc1_gecerli_c), 0);
        gonder(0, c_add, 32'd100, 32'd23);
        bekle_sonuc(0);
        repeat (3) @(negedge clk_g);

        // 4: continuous contention, four operations
        sifirla();
        kabul_sirasi.delete();
        fork
            begin
                gonder(0, c_or, 32'hA0, 32'h05);
                gonder(0, c_and, 32'hFFFF, 32'h0F0F);
            end
            begin
                gonder(1, c_sub, 32'd0, 32'd1);
                gonder(1, c_add, 32'hFFFFFFFF, 32'd2);
            end
        join
        repeat (6) @(negedge clk_g);
        sira_kontrol(4);

        // 5: asynchronous reset while an AND result is held
        @(posedge clk_g); #1;
        sonuc0_hazir_g = 1'b0;
        gonder(0, c_and, 32'hF0F0F0F0, 32'hFF00FF00);
        bekle_sonuc(0);
        kontrol("t5_held_value", sonuc_c, 32'hF000F000);
        #2 rst_g = 1'b1;
        istek1_gecerli_g = 1'b1;
        #1 sifir_kontrol();
        istek1_gecerli_g = 1'b0;
        q_deger[0].delete(); q_deger[1].delete();
        q_cyc[0].delete();   q_cyc[1].delete();
        ilk[0] = 1'b0; ilk[1] = 1'b0; bosta_bekle = 1'b0;
        repeat (2) @(posedge clk_g);
        #1 rst_g = 1'b0;
        sonuc0_hazir_g = 1'b1;
        repeat (5) @(negedge clk_g);
        kontrol("t5_idle_after_reset", 32'(mesgul_c), 0);
        kabul_sirasi.delete();
        @(posedge clk_g); #1;
        fork
            gonder(0, c_xor, 32'h1234, 32'h4321);
            gonder(1, c_add, 32'd40, 32'd2);
        join
        repeat (6) @(negedge clk_g);
        sira_kontrol(2);

        // Randomized traffic with random result backpressure
        d0 = 1'b0; d1 = 1'b0;
        fork
            begin
                for (int i = 0; i < 15; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk_g);
                    #1 gonder(0, kodlar[$urandom_range(0, 5)], $urandom, $urandom);
                end
                d0 = 1'b1;
            end
            begin
                for (int i = 0; i < 15; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk_g);
                    #1 gonder(1, kodlar[$urandom_range(0, 5)], $urandom, $urandom);
                end
                d1 = 1'b1;
            end
            begin
                for (int i = 0; i < 3000 && !(d0 && d1); i++) begin
                    @(posedge clk_g);
                    #1;
                    sonuc0_hazir_g = ($urandom_range(0, 3) != 0);
                    sonuc1_hazir_g = ($urandom_range(0, 3) != 0);
                end
            end
        join

        // Drain outstanding results
        sonuc0_hazir_g = 1'b1; sonuc1_hazir_g = 1'b1;
        for (int i = 0; i < 50 && (q_deger[0].size() + q_deger[1].size()) != 0; i++)
            @(negedge clk_g);
        kontrol("scoreboard_drained", 32'(q_deger[0].size() + q_deger[1].size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_test, n_hata);
        $finish;
    end

endmodule
`default_nettype wire
